// File: rtl/pulse_arbiter.sv
// pulse_arbiter: latches request rising edges and serves them one at a time as ID-tagged
// PULSE_WIDTH-cycle pulses followed by DEAD_TIME guard cycles. Define PULSE_ARB_FIXED_PRI_EN for fixed priority.
module pulse_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ID_WIDTH      = 2,
  parameter int PULSE_WIDTH   = 1,
  parameter int DEAD_TIME     = 100,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [N_REQ-1:0]    req,
  input  logic                drop_clr,
  output logic                pulse,
  output logic [ID_WIDTH-1:0] pulse_id,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    pending,
  output logic [N_REQ-1:0]    dropped,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, PULSE, DEAD} state_t;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]         req_prev_q;
  logic [N_REQ-1:0]         pend_q, pend_d;
  logic [N_REQ-1:0]         drop_q, drop_d;
  logic [N_REQ-1:0]         grant_q, grant_d;
  logic                     pulse_q, pulse_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [N_REQ-1:0]         edge_v;
  logic [N_REQ-1:0]         win_vec;
  logic [ID_WIDTH-1:0]      win_id;
  logic                     win_vld;
`ifndef PULSE_ARB_FIXED_PRI_EN
  logic [ID_WIDTH-1:0]      ptr_q, ptr_d;
  int                       idx;
`endif

  assign edge_v = req & ~req_prev_q;

  // Loops run from lowest search priority to highest so the last hit is the winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
`ifdef PULSE_ARB_FIXED_PRI_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        win_vld = 1'b1;
        win_id  = ID_WIDTH'(i);
      end
    end
`else
    idx = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (pend_q[idx]) begin
        win_vld = 1'b1;
        win_id  = ID_WIDTH'(idx);
      end
    end
`endif
    win_vec = N_REQ'(1) << win_id;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    id_d    = id_q;
    grant_d = '0;
`ifndef PULSE_ARB_FIXED_PRI_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        if (enable && win_vld) begin
          pulse_d = 1'b1;
          id_d    = win_id;
          grant_d = win_vec;
          cnt_d   = COUNTER_WIDTH'(PULSE_WIDTH - 1);
          state_d = PULSE;
`ifndef PULSE_ARB_FIXED_PRI_EN
          ptr_d   = win_id;
`endif
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          pulse_d = 1'b0;
          if (DEAD_TIME == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = COUNTER_WIDTH'(DEAD_TIME - 1);
            state_d = DEAD;
          end
        end else begin
          cnt_d = cnt_q - COUNTER_WIDTH'(1);
        end
      end
      DEAD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - COUNTER_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the channel being granted re-arms it rather than counting as a drop.
    pend_d = (pend_q & ~grant_d) | edge_v;
    drop_d = (drop_clr ? '0 : drop_q) | (edge_v & pend_q & ~grant_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_prev_q <= '0;
      pend_q     <= '0;
      drop_q     <= '0;
      grant_q    <= '0;
      pulse_q    <= 1'b0;
      id_q       <= '0;
`ifndef PULSE_ARB_FIXED_PRI_EN
      ptr_q      <= ID_WIDTH'(N_REQ - 1);
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_prev_q <= req;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      grant_q    <= grant_d;
      pulse_q    <= pulse_d;
      id_q       <= id_d;
`ifndef PULSE_ARB_FIXED_PRI_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign pulse    = pulse_q;
  assign pulse_id = id_q;
  assign grant    = grant_q;
  assign pending  = pend_q;
  assign dropped  = drop_q;
  assign busy     = (state_q != IDLE);

endmodule
